// File: rtl/stream_tx_driver.sv
// Ready/valid stream source with a small FIFO and LFSR-driven bubble insertion.
// Carries a transfer counter so scoreboards can track completed beats.
module stream_tx_driver #(
    parameter type         T        = logic,
    parameter int unsigned Depth    = 4,
    parameter logic [15:0] LfsrSeed = 16'hACE1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  T                         push_data_i,
    input  logic                     enable_i,
    input  logic [7:0]               stall_prob_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output T                         data_o,
    output logic [$clog2(Depth):0]   fifo_cnt_o,
    output logic [31:0]              tx_cnt_o,
    output logic                     idle_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state;
    T                mem [Depth];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic [15:0]     lfsr;
    logic [31:0]     tx_cnt;
    logic            push;
    logic            pop;
    logic            go;
    logic            fb;

    // Full check uses the registered count only, so a pop never frees a slot early
    assign push_ready_o = (cnt < CW'(Depth));
    assign push         = push_valid_i & push_ready_o;
    assign pop          = (state == SEND) & ready_i;
    assign go           = enable_i & (lfsr[7:0] >= stall_prob_i);
    assign fb           = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    assign valid_o    = (state == SEND);
    assign data_o     = mem[rd_ptr];
    assign fifo_cnt_o = cnt;
    assign tx_cnt_o   = tx_cnt;
    assign idle_o     = (state == IDLE) && (cnt == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    // Pointers wrap naturally since Depth is a power of two
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            tx_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                tx_cnt <= tx_cnt + 32'd1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr <= LfsrSeed;
        end else begin
            lfsr <= {fb, lfsr[15:1]};
        end
    end

    // Once in SEND, valid is held until the handshake regardless of go
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if ((cnt != '0) && go) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (ready_i && !((cnt > CW'(1)) && go)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
